// File: rtl/pwm_pkg.sv
// Shared PWM definitions: nominal period, timeout window, capture state encoding
// and the direction-to-sign mapping used by capture and generator blocks.
package pwm_pkg;

  localparam int PWM_MAX_COUNT      = 4000;
  localparam int PWM_TIMEOUT_CYCLES = 8192;

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_MEASURE    = 2'd1,
    ST_TIMEOUT    = 2'd2
  } cap_state_t;

  // 10 = forward, 01 = reverse, 00 and 11 = no drive.
  function automatic logic signed [15:0] apply_dir(input logic [15:0] mag,
                                                   input logic dir1,
                                                   input logic dir2);
    logic signed [15:0] res;
    res = '0;
    case ({dir1, dir2})
      2'b10:   res = $signed(mag);
      2'b01:   res = -$signed(mag);
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pwm_capture_bidirectional_input_sync.sv
// Two-flop synchronizer for one asynchronous line, with an optional
// rising-edge strobe derived from a third (delayed) flop.
module input_sync #(
  parameter bit RISE_EN = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic meta;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta   <= din;
      sync_q <= meta;
    end
  end

  assign sync = sync_q;

  if (RISE_EN) begin : g_rise
    logic dly;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dly <= 1'b0;
      else          dly <= sync_q;
    end
    assign rise = sync_q & ~dly;
  end else begin : g_no_rise
    assign rise = 1'b0;
  end

endmodule

// File: rtl/pwm_capture_bidirectional.sv
// Measures PWM period and high time, signs the duty by the direction lines and
// reports a signed control value; flags loss of PWM edges as a timeout.
module pwm_capture_bidirectional
  import pwm_pkg::*;
#(
  parameter int MAX_COUNT      = PWM_MAX_COUNT,
  parameter int TIMEOUT_CYCLES = PWM_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pwm_in,
  input  logic               dir1_in,
  input  logic               dir2_in,
  output logic signed [15:0] measured_signal,
  output logic [15:0]        period_count,
  output logic               meas_valid,
  output logic               timeout,
  output logic               dir_fault
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || MAX_COUNT < 1 || MAX_COUNT > 32767)
  begin : g_param_check
    $error("pwm_capture_bidirectional: parameter out of range");
  end

  localparam logic [15:0] MAX16   = 16'(MAX_COUNT);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic pwm_s, pwm_rise;
  logic dir1_s, dir2_s;
  logic dir1_rise_unused, dir2_rise_unused;

  input_sync #(.RISE_EN(1'b1)) u_sync_pwm (
    .clk(clk), .reset_n(reset_n), .din(pwm_in), .sync(pwm_s), .rise(pwm_rise)
  );
  input_sync #(.RISE_EN(1'b0)) u_sync_dir1 (
    .clk(clk), .reset_n(reset_n), .din(dir1_in), .sync(dir1_s), .rise(dir1_rise_unused)
  );
  input_sync #(.RISE_EN(1'b0)) u_sync_dir2 (
    .clk(clk), .reset_n(reset_n), .din(dir2_in), .sync(dir2_s), .rise(dir2_rise_unused)
  );

  cap_state_t  state, state_nxt;
  logic [15:0] period_cnt, high_cnt;
  logic        do_meas, do_to, cnt_restart, cnt_zero, cnt_last;

  assign cnt_last = (period_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_WAIT_FIRST;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    do_meas     = 1'b0;
    do_to       = 1'b0;
    cnt_restart = 1'b0;
    cnt_zero    = 1'b0;
    case (state)
      ST_WAIT_FIRST, ST_TIMEOUT: begin
        // An edge here opens a period but closes nothing worth reporting.
        if (pwm_rise) begin
          state_nxt   = ST_MEASURE;
          cnt_restart = 1'b1;
        end else if (cnt_last) begin
          state_nxt = ST_TIMEOUT;
          do_to     = 1'b1;
          cnt_zero  = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (pwm_rise) begin
          do_meas     = 1'b1;
          cnt_restart = 1'b1;
        end else if (cnt_last) begin
          state_nxt = ST_TIMEOUT;
          do_to     = 1'b1;
          cnt_zero  = 1'b1;
        end
      end
      default: state_nxt = ST_WAIT_FIRST;
    endcase
  end

  // The closing edge cycle is the first (high) cycle of the next period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (cnt_restart) begin
      period_cnt <= 16'd1;
      high_cnt   <= 16'd1;
    end else if (cnt_zero) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else begin
      period_cnt <= period_cnt + 16'd1;
      if (pwm_s && high_cnt != 16'hFFFF) high_cnt <= high_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      measured_signal <= '0;
      period_count    <= '0;
      meas_valid      <= 1'b0;
      timeout         <= 1'b0;
      dir_fault       <= 1'b0;
    end else begin
      meas_valid <= do_meas | do_to;
      timeout    <= (state_nxt == ST_TIMEOUT);
      if (do_meas) begin
        period_count    <= period_cnt;
        measured_signal <= apply_dir((high_cnt > MAX16) ? MAX16 : high_cnt, dir1_s, dir2_s);
        dir_fault       <= dir1_s & dir2_s;
      end else if (do_to) begin
        // With no edges the line level alone says full-on or off.
        period_count    <= '0;
        measured_signal <= apply_dir(pwm_s ? MAX16 : 16'd0, dir1_s, dir2_s);
        dir_fault       <= dir1_s & dir2_s;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture_bidirectional.sv
// Directed bench for pwm_capture_bidirectional: generator-like PWM patterns,
// direction combinations, timeout entry/exit and mid-period reset.
module tb_pwm_capture_bidirectional;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               pwm_in = 1'b0;
  logic               dir1_in = 1'b0;
  logic               dir2_in = 1'b0;
  logic signed [15:0] measured_signal;
  logic [15:0]        period_count;
  logic               meas_valid;
  logic               timeout;
  logic               dir_fault;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int mv_count = 0;
  int mv_long = 0;
  int mv_last_cyc = 0;
  int mv_prev_cyc = 0;
  int to_rise_cyc = 0;
  int last_rise_cyc = 0;
  bit mv_prev_s = 1'b0;
  bit to_prev = 1'b0;

  pwm_capture_bidirectional dut (
    .clk(clk), .reset_n(reset_n), .pwm_in(pwm_in), .dir1_in(dir1_in), .dir2_in(dir2_in),
    .measured_signal(measured_signal), .period_count(period_count),
    .meas_valid(meas_valid), .timeout(timeout), .dir_fault(dir_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (meas_valid) begin
      if (mv_prev_s) mv_long++;
      mv_count++;
      mv_prev_cyc = mv_last_cyc;
      mv_last_cyc = cyc;
    end
    mv_prev_s = meas_valid;
    if (timeout && !to_prev) to_rise_cyc = cyc;
    to_prev = timeout;
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic run_pwm(input int high, input int period, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < period; i++) begin
        pwm_in = (i < high);
        if (i == 0) last_rise_cyc = cyc;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    dir1_in = 1'b0;
    dir2_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pwm_in  = 1'b1;
    dir1_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if (measured_signal !== 16'sd0) begin bad++; $display("FAIL reset_measured got=%0d exp=0", measured_signal); end
    total++; if (period_count !== 16'd0) begin bad++; $display("FAIL reset_period got=%0d exp=0", period_count); end
    total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", meas_valid); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    total++; if (dir_fault !== 1'b0) begin bad++; $display("FAIL reset_dir_fault got=%b exp=0", dir_fault); end
  endtask

  task automatic test_forward();
    int got;
    int pulses;
    logic signed [15:0] meas_at;
    logic [15:0] per_at;
    int mv0;
    do_reset();
    dir1_in = 1'b1;
    dir2_in = 1'b0;
    run_pwm(1000, 4000, 1);
    got = 0; pulses = 0; meas_at = '0; per_at = '0;
    pwm_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (meas_valid) begin
        pulses++;
        if (got == 0) begin got = i; meas_at = measured_signal; per_at = period_count; end
      end
    end
    for (int i = 8; i < 4000; i++) begin
      pwm_in = (i < 1000);
      @(posedge clk);
      #1;
    end
    total++; if (got !== 3) begin bad++; $display("FAIL fwd_latency got=%0d exp=3", got); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL fwd_pulse_width got=%0d exp=1", pulses); end
    total++; if (meas_at !== 16'sd1000) begin bad++; $display("FAIL fwd_first_meas got=%0d exp=1000", meas_at); end
    total++; if (per_at !== 16'd4000) begin bad++; $display("FAIL fwd_first_period got=%0d exp=4000", per_at); end
    settle();
    mv0 = mv_count;
    run_pwm(1000, 4000, 1);
    settle();
    total++; if (mv_count - mv0 !== 1) begin bad++; $display("FAIL fwd_pulse_count got=%0d exp=1", mv_count - mv0); end
    total++; if (mv_last_cyc - mv_prev_cyc !== 4000) begin bad++; $display("FAIL fwd_spacing got=%0d exp=4000", mv_last_cyc - mv_prev_cyc); end
    total++; if (measured_signal !== 16'sd1000) begin bad++; $display("FAIL fwd_meas got=%0d exp=1000", measured_signal); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL fwd_timeout got=%b exp=0", timeout); end
  endtask

  task automatic test_reverse();
    int mv0;
    do_reset();
    dir1_in = 1'b0;
    dir2_in = 1'b1;
    mv0 = mv_count;
    run_pwm(2500, 4000, 2);
    settle();
    total++; if (mv_count - mv0 !== 1) begin bad++; $display("FAIL rev_pulse_count got=%0d exp=1", mv_count - mv0); end
    total++; if (measured_signal !== -16'sd2500) begin bad++; $display("FAIL rev_meas got=%0d exp=-2500", measured_signal); end
    total++; if (period_count !== 16'd4000) begin bad++; $display("FAIL rev_period got=%0d exp=4000", period_count); end
    total++; if (dir_fault !== 1'b0) begin bad++; $display("FAIL rev_dir_fault got=%b exp=0", dir_fault); end
  endtask

  task automatic test_timeout_low();
    int mv0;
    do_reset();
    mv0 = mv_count;
    run_pwm(1000, 4000, 1);
    pwm_in = 1'b0;
    repeat (9000) @(posedge clk);
    settle();
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL tlow_timeout got=%b exp=1", timeout); end
    total++; if (to_rise_cyc - last_rise_cyc !== 8194) begin bad++; $display("FAIL tlow_delay got=%0d exp=8194", to_rise_cyc - last_rise_cyc); end
    total++; if (measured_signal !== 16'sd0) begin bad++; $display("FAIL tlow_meas got=%0d exp=0", measured_signal); end
    total++; if (period_count !== 16'd0) begin bad++; $display("FAIL tlow_period got=%0d exp=0", period_count); end
    total++; if (mv_count - mv0 !== 1) begin bad++; $display("FAIL tlow_pulse_count got=%0d exp=1", mv_count - mv0); end
  endtask

  task automatic test_timeout_high();
    int mv0;
    do_reset();
    dir1_in = 1'b1;
    dir2_in = 1'b0;
    run_pwm(1000, 4000, 1);
    pwm_in = 1'b1;
    repeat (8300) @(posedge clk);
    settle();
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL thigh_timeout got=%b exp=1", timeout); end
    total++; if (measured_signal !== 16'sd4000) begin bad++; $display("FAIL thigh_meas got=%0d exp=4000", measured_signal); end
    total++; if (period_count !== 16'd0) begin bad++; $display("FAIL thigh_period got=%0d exp=0", period_count); end
    pwm_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    mv0 = mv_count;
    run_pwm(1000, 4000, 1);
    settle();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL thigh_exit got=%b exp=0", timeout); end
    total++; if (mv_count - mv0 !== 0) begin bad++; $display("FAIL thigh_partial got=%0d exp=0", mv_count - mv0); end
    run_pwm(1000, 4000, 1);
    settle();
    total++; if (mv_count - mv0 !== 1) begin bad++; $display("FAIL thigh_resume_count got=%0d exp=1", mv_count - mv0); end
    total++; if (measured_signal !== 16'sd1000) begin bad++; $display("FAIL thigh_resume_meas got=%0d exp=1000", measured_signal); end
    total++; if (period_count !== 16'd4000) begin bad++; $display("FAIL thigh_resume_period got=%0d exp=4000", period_count); end
  endtask

  task automatic test_dir_fault();
    do_reset();
    dir1_in = 1'b1;
    dir2_in = 1'b1;
    run_pwm(1500, 4000, 2);
    settle();
    total++; if (measured_signal !== 16'sd0) begin bad++; $display("FAIL df_meas got=%0d exp=0", measured_signal); end
    total++; if (dir_fault !== 1'b1) begin bad++; $display("FAIL df_flag got=%b exp=1", dir_fault); end
    total++; if (period_count !== 16'd4000) begin bad++; $display("FAIL df_period got=%0d exp=4000", period_count); end
    dir2_in = 1'b0;
    run_pwm(1500, 4000, 1);
    settle();
    total++; if (dir_fault !== 1'b0) begin bad++; $display("FAIL df_clear got=%b exp=0", dir_fault); end
    total++; if (measured_signal !== 16'sd1500) begin bad++; $display("FAIL df_fwd_meas got=%0d exp=1500", measured_signal); end
  endtask

  task automatic test_reset_mid();
    int mv0;
    do_reset();
    dir1_in = 1'b1;
    dir2_in = 1'b0;
    run_pwm(1000, 4000, 2);
    pwm_in = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    total++; if (measured_signal !== 16'sd1000) begin bad++; $display("FAIL rmid_before got=%0d exp=1000", measured_signal); end
    reset_n = 1'b0;
    #2;
    total++; if (measured_signal !== 16'sd0) begin bad++; $display("FAIL rmid_meas got=%0d exp=0", measured_signal); end
    total++; if (period_count !== 16'd0) begin bad++; $display("FAIL rmid_period got=%0d exp=0", period_count); end
    pwm_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    mv0 = mv_count;
    run_pwm(1000, 4000, 1);
    settle();
    total++; if (mv_count - mv0 !== 0) begin bad++; $display("FAIL rmid_first_edge got=%0d exp=0", mv_count - mv0); end
    run_pwm(1000, 4000, 1);
    settle();
    total++; if (mv_count - mv0 !== 1) begin bad++; $display("FAIL rmid_second_edge got=%0d exp=1", mv_count - mv0); end
    total++; if (measured_signal !== 16'sd1000) begin bad++; $display("FAIL rmid_meas_after got=%0d exp=1000", measured_signal); end
    total++; if (period_count !== 16'd4000) begin bad++; $display("FAIL rmid_period_after got=%0d exp=4000", period_count); end
  endtask

  task automatic test_pulse_width();
    total++; if (mv_long !== 0) begin bad++; $display("FAIL valid_single_cycle got=%0d exp=0", mv_long); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_timeout_low();
    test_timeout_high();
    test_dir_fault();
    test_reset_mid();
    test_pulse_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
